// File: rtl/uart_proto_pkg.sv
package uart_proto_pkg;

  typedef enum logic [7:0] {
    MSG_INFO     = 8'd0,
    MSG_INVALID  = 8'd1,
    MSG_PUSH_JOB = 8'd2,
    MSG_NONCE    = 8'd3,
    MSG_ACK      = 8'd4
  } msg_type_e;

  localparam int unsigned HDR_LEN   = 8;
  localparam int unsigned JOB_BYTES = 52;
  localparam int unsigned PUSH_LEN  = 60;
  localparam int unsigned INFO_LEN  = 16;
  localparam int unsigned NONCE_LEN = 12;
  localparam int unsigned ACK_LEN   = 8;
  localparam int unsigned PKT_BITS  = PUSH_LEN * 8;

  function automatic logic [PKT_BITS-1:0] build_push(input logic [JOB_BYTES*8-1:0] job);
    return {8'(PUSH_LEN), 16'h0000, MSG_PUSH_JOB, 32'h0000_0000, job};
  endfunction

  function automatic logic [PKT_BITS-1:0] build_info();
    return {8'(HDR_LEN), 16'h0000, MSG_INFO, 32'h0000_0000, {(JOB_BYTES*8){1'b0}}};
  endfunction

endpackage

// File: rtl/uart_host_rx_parser.sv
module uart_host_rx_parser
  import uart_proto_pkg::*;
#(
  parameter int unsigned RX_GAP_TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  output logic        pkt_ack,
  output logic        pkt_invalid,
  output logic        pkt_info,
  output logic        pkt_nonce,
  output logic        pkt_error,
  output logic [63:0] payload
);

  typedef enum logic {RX_IDLE, RX_BODY} rx_state_e;

  rx_state_e   state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  type_q, type_d;
  logic [31:0] gap_q, gap_d;
  logic [63:0] payload_q, payload_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      type_q    <= '0;
      gap_q     <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      type_q    <= type_d;
      gap_q     <= gap_d;
      payload_q <= payload_d;
    end
  end

  // Strobes are combinational in the final byte's cycle so the top can register them.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    type_d      = type_q;
    gap_d       = gap_q;
    payload_d   = payload_q;
    pkt_ack     = 1'b0;
    pkt_invalid = 1'b0;
    pkt_info    = 1'b0;
    pkt_nonce   = 1'b0;
    pkt_error   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (received) begin
          len_d     = rx_byte;
          idx_d     = 8'd1;
          type_d    = '0;
          gap_d     = '0;
          payload_d = '0;
          if (rx_byte >= 8'(HDR_LEN)) begin
            state_d = RX_BODY;
          end else if (rx_byte != 8'd1) begin
            pkt_error = 1'b1;
          end
        end
      end
      RX_BODY: begin
        if (received) begin
          gap_d = '0;
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'd3) begin
            type_d = rx_byte;
          end
          if (idx_q >= 8'(HDR_LEN)) begin
            payload_d = {payload_q[55:0], rx_byte};
          end
          if (idx_q == len_q - 8'd1) begin
            state_d = RX_IDLE;
            case (type_q)
              MSG_ACK:     if (len_q == 8'(ACK_LEN))   pkt_ack     = 1'b1; else pkt_error = 1'b1;
              MSG_INVALID: if (len_q == 8'(HDR_LEN))   pkt_invalid = 1'b1; else pkt_error = 1'b1;
              MSG_INFO:    if (len_q == 8'(INFO_LEN))  pkt_info    = 1'b1; else pkt_error = 1'b1;
              MSG_NONCE:   if (len_q == 8'(NONCE_LEN)) pkt_nonce   = 1'b1; else pkt_error = 1'b1;
              default:     pkt_error = 1'b1;
            endcase
          end
        end else if (gap_q >= RX_GAP_TIMEOUT) begin
          pkt_error = 1'b1;
          state_d   = RX_IDLE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign payload = payload_d;

endmodule

// File: rtl/uart_host_link.sv
module uart_host_link
  import uart_proto_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT    = 12000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned RX_GAP_TIMEOUT = 20000
) (
  input  logic                   comm_clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [JOB_BYTES*8-1:0] job_data,
  input  logic                   info_req,
  output logic [7:0]             tx_byte,
  output logic                   transmit,
  input  logic                   is_transmitting,
  input  logic [7:0]             rx_byte,
  input  logic                   received,
  output logic [31:0]            nonce,
  output logic                   nonce_valid,
  output logic [63:0]            info_data,
  output logic                   info_valid,
  output logic                   job_acked,
  output logic                   job_failed,
  output logic                   proto_error,
  output logic                   busy
);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT_RESP} tx_state_e;

  tx_state_e           state_q, state_d;
  logic                is_job_q, is_job_d;
  logic [5:0]          len_q, len_d;
  logic [5:0]          idx_q, idx_d;
  logic [PKT_BITS-1:0] buf_q, buf_d;
  logic                strobe_q, strobe_d;
  logic [31:0]         timer_q, timer_d;
  logic [31:0]         retry_q, retry_d;
  logic [31:0]         nonce_q, nonce_d;
  logic                nonce_valid_q, nonce_valid_d;
  logic [63:0]         info_data_q, info_data_d;
  logic                info_valid_q, info_valid_d;
  logic                job_acked_q, job_acked_d;
  logic                job_failed_q, job_failed_d;
  logic                proto_error_q, proto_error_d;

  logic        rx_ack, rx_invalid, rx_info, rx_nonce, rx_error;
  logic [63:0] rx_payload;

  uart_host_rx_parser #(
    .RX_GAP_TIMEOUT(RX_GAP_TIMEOUT)
  ) u_rx_parser (
    .clk        (comm_clk),
    .reset      (reset),
    .received   (received),
    .rx_byte    (rx_byte),
    .pkt_ack    (rx_ack),
    .pkt_invalid(rx_invalid),
    .pkt_info   (rx_info),
    .pkt_nonce  (rx_nonce),
    .pkt_error  (rx_error),
    .payload    (rx_payload)
  );

  always_ff @(posedge comm_clk) begin
    if (reset) begin
      state_q       <= TX_IDLE;
      is_job_q      <= 1'b0;
      len_q         <= '0;
      idx_q         <= '0;
      buf_q         <= '0;
      strobe_q      <= 1'b0;
      timer_q       <= '0;
      retry_q       <= '0;
      nonce_q       <= '0;
      nonce_valid_q <= 1'b0;
      info_data_q   <= '0;
      info_valid_q  <= 1'b0;
      job_acked_q   <= 1'b0;
      job_failed_q  <= 1'b0;
      proto_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_job_q      <= is_job_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      strobe_q      <= strobe_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      nonce_q       <= nonce_d;
      nonce_valid_q <= nonce_valid_d;
      info_data_q   <= info_data_d;
      info_valid_q  <= info_valid_d;
      job_acked_q   <= job_acked_d;
      job_failed_q  <= job_failed_d;
      proto_error_q <= proto_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    is_job_d      = is_job_q;
    len_d         = len_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    nonce_d       = nonce_q;
    info_data_d   = info_data_q;
    nonce_valid_d = 1'b0;
    info_valid_d  = 1'b0;
    job_acked_d   = 1'b0;
    job_failed_d  = 1'b0;

    transmit = !reset && (state_q == TX_SEND) && !is_transmitting && !strobe_q;
    tx_byte  = transmit ? buf_q[PKT_BITS-1 -: 8] : '0;
    strobe_d = transmit;

    proto_error_d = rx_error
                  || (rx_ack  && !((state_q == TX_WAIT_RESP) &&  is_job_q))
                  || (rx_info && !((state_q == TX_WAIT_RESP) && !is_job_q));

    if (rx_nonce) begin
      nonce_d       = rx_payload[31:0];
      nonce_valid_d = 1'b1;
    end

    case (state_q)
      TX_IDLE: begin
        if (job_valid) begin
          is_job_d = 1'b1;
          len_d    = 6'(PUSH_LEN);
          buf_d    = build_push(job_data);
          idx_d    = '0;
          retry_d  = '0;
          state_d  = TX_SEND;
        end else if (info_req) begin
          is_job_d = 1'b0;
          len_d    = 6'(HDR_LEN);
          buf_d    = build_info();
          idx_d    = '0;
          retry_d  = '0;
          state_d  = TX_SEND;
        end
      end
      TX_SEND: begin
        if (transmit) begin
          // Rotate rather than shift: a full 60-byte pass restores the job for resends.
          buf_d = {buf_q[PKT_BITS-9:0], buf_q[PKT_BITS-1 -: 8]};
          idx_d = idx_q + 6'd1;
          if (idx_q == len_q - 6'd1) begin
            idx_d   = '0;
            timer_d = '0;
            state_d = TX_WAIT_RESP;
          end
        end
      end
      TX_WAIT_RESP: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 32'd1;
        if (rx_ack && is_job_q) begin
          job_acked_d = 1'b1;
          state_d     = TX_IDLE;
        end else if (rx_info && !is_job_q) begin
          info_data_d  = rx_payload;
          info_valid_d = 1'b1;
          state_d      = TX_IDLE;
        end else if (rx_invalid || (timer_q >= ACK_TIMEOUT)) begin
          if (retry_q < MAX_RETRIES) begin
            retry_d = retry_q + 32'd1;
            state_d = TX_SEND;
            if (!is_job_q) begin
              buf_d = build_info();
            end
          end else begin
            if (is_job_q) begin
              job_failed_d = 1'b1;
            end else begin
              proto_error_d = 1'b1;
            end
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign job_ready   = (state_q == TX_IDLE) && !reset;
  assign busy        = (state_q != TX_IDLE);
  assign nonce       = nonce_q;
  assign nonce_valid = nonce_valid_q;
  assign info_data   = info_data_q;
  assign info_valid  = info_valid_q;
  assign job_acked   = job_acked_q;
  assign job_failed  = job_failed_q;
  assign proto_error = proto_error_q;

endmodule

// File: tb/tb_uart_host_link.sv
module tb_uart_host_link;

  localparam int unsigned T_ACK   = 100;
  localparam int unsigned T_RETRY = 2;
  localparam int unsigned T_GAP   = 40;

  logic         comm_clk = 1'b0;
  logic         reset = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [415:0] job_data = '0;
  logic         info_req = 1'b0;
  logic [7:0]   tx_byte;
  logic         transmit;
  logic         is_transmitting;
  logic [7:0]   rx_byte = '0;
  logic         received = 1'b0;
  logic [31:0]  nonce;
  logic         nonce_valid;
  logic [63:0]  info_data;
  logic         info_valid;
  logic         job_acked, job_failed, proto_error, busy;

  uart_host_link #(
    .ACK_TIMEOUT   (T_ACK),
    .MAX_RETRIES   (T_RETRY),
    .RX_GAP_TIMEOUT(T_GAP)
  ) dut (
    .comm_clk       (comm_clk),
    .reset          (reset),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_data       (job_data),
    .info_req       (info_req),
    .tx_byte        (tx_byte),
    .transmit       (transmit),
    .is_transmitting(is_transmitting),
    .rx_byte        (rx_byte),
    .received       (received),
    .nonce          (nonce),
    .nonce_valid    (nonce_valid),
    .info_data      (info_data),
    .info_valid     (info_valid),
    .job_acked      (job_acked),
    .job_failed     (job_failed),
    .proto_error    (proto_error),
    .busy           (busy)
  );

  always #5 comm_clk = ~comm_clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // UART model: every accepted byte keeps the line busy for 10 cycles.
  logic [7:0]  txq[$];
  int unsigned busy_cnt = 0;
  logic        prev_tx = 1'b0;
  int unsigned guard_viol = 0, reset_tx = 0;
  int unsigned n_acked = 0, n_failed = 0, n_info = 0, n_nonce = 0, n_perr = 0;

  assign is_transmitting = (busy_cnt != 0);

  always @(posedge comm_clk) begin
    prev_tx <= transmit;
    if (transmit) begin
      txq.push_back(tx_byte);
      busy_cnt <= 10;
      if (is_transmitting || prev_tx) guard_viol <= guard_viol + 1;
      if (reset) reset_tx <= reset_tx + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (job_acked)   n_acked  <= n_acked + 1;
    if (job_failed)  n_failed <= n_failed + 1;
    if (info_valid)  n_info   <= n_info + 1;
    if (nonce_valid) n_nonce  <= n_nonce + 1;
    if (proto_error) n_perr   <= n_perr + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge comm_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge comm_clk);
    received = 1'b1;
    rx_byte  = b;
    @(negedge comm_clk);
    received = 1'b0;
  endtask

  // bytes are left-justified: byte0 in [127:120]
  task automatic send_pkt(input logic [127:0] bytes, input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[127-8*i -: 8]);
  endtask

  task automatic wait_tx(input string name, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (txq.size() >= n) break;
      @(negedge comm_clk);
    end
    chk(name, 64'(txq.size()), 64'(n));
  endtask

  task automatic start_job(input logic [415:0] j);
    @(negedge comm_clk);
    job_valid = 1'b1;
    job_data  = j;
    @(negedge comm_clk);
    job_valid = 1'b0;
  endtask

  // Reference model: packet bytes as the wire format describes them.
  logic [7:0] exp_pkt[60];

  task automatic model_push(input logic [415:0] j);
    for (int i = 0; i < 8; i++) exp_pkt[i] = 8'h00;
    exp_pkt[0] = 8'd60;
    exp_pkt[3] = 8'd2;
    for (int i = 0; i < 52; i++) exp_pkt[8+i] = 8'(j >> (8*(51-i)));
  endtask

  task automatic chk_pkt(input string name, input int base);
    int mism = 0;
    for (int i = 0; i < 60; i++)
      if (base + i >= txq.size() || txq[base+i] !== exp_pkt[i]) mism++;
    chk(name, 64'(mism), 64'd0);
  endtask

  // {proto_error, nonce_valid} for a received packet while no response is awaited
  function automatic logic [1:0] model_rx(input logic [7:0] len, input logic [7:0] typ);
    if (len == 8'd1) return 2'b00;
    if (len < 8'd8)  return 2'b10;
    if (typ == 8'd3) return (len == 8'd12) ? 2'b01 : 2'b10;
    if (typ == 8'd1) return (len == 8'd8)  ? 2'b00 : 2'b10;
    return 2'b10;
  endfunction

  typedef struct {
    string        name;
    int           n;
    logic [127:0] bytes;
    logic         exp_err;
    logic         exp_nonce;
    logic [31:0]  exp_val;
  } rx_vec_t;

  localparam logic [127:0] ACK_PKT     = 128'h08000004_00000000_00000000_00000000;
  localparam logic [127:0] INVALID_PKT = 128'h08000001_00000000_00000000_00000000;

  rx_vec_t      vecs[10];
  logic [415:0] job;
  logic [255:0] mid;
  logic [127:0] pk;
  logic [7:0]   rl, rt;
  logic [1:0]   exp_rx;
  logic [63:0]  acc;
  int unsigned  a0, f0, p0, i0, nn0, s0;

  initial begin
    // ---------------- reset state
    repeat (3) @(negedge comm_clk);
    chk("rst_transmit", 64'(transmit), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'd0);
    chk("rst_nonce", 64'(nonce), 64'd0);
    chk("rst_info_data", info_data, 64'd0);
    chk("rst_pulses", 64'({nonce_valid, info_valid, job_acked, job_failed, proto_error}), 64'd0);
    reset = 1'b0;
    @(negedge comm_clk);
    chk("rst_job_ready", 64'(job_ready), 64'd1);

    // ---------------- job push, ACK
    for (int i = 0; i < 32; i++) mid[255-8*i -: 8] = 8'(i);
    job = {mid, $urandom, $urandom, $urandom, 32'h0000_0000, 32'hFFFF_FFFF};
    model_push(job);
    txq.delete();
    a0 = n_acked; f0 = n_failed;
    start_job(job);
    chk("ready_drop", 64'(job_ready), 64'd0);
    chk("first_transmit", 64'(transmit), 64'd1);
    chk("first_tx_byte", 64'(tx_byte), 64'(exp_pkt[0]));
    wait_tx("push_tx_count", 60, 2000);
    chk_pkt("push_pkt", 0);
    chk("push_byte9", 64'(txq[9]), 64'h01);
    send_pkt(ACK_PKT, 8);
    chk("ack_pulse", 64'(job_acked), 64'd1);
    cycles(3);
    chk("ack_count", 64'(n_acked - a0), 64'd1);
    chk("ack_no_fail", 64'(n_failed - f0), 64'd0);
    chk("ready_back", 64'(job_ready), 64'd1);
    chk("busy_clear", 64'(busy), 64'd0);

    // ---------------- retries exhausted
    job = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    model_push(job);
    txq.delete();
    a0 = n_acked; f0 = n_failed;
    start_job(job);
    wait_tx("retry_tx_count", 60 * (T_RETRY + 1), 8000);
    for (int k = 0; k <= T_RETRY; k++) chk_pkt($sformatf("retry_pkt%0d", k), 60 * k);
    for (int i = 0; i < 1000; i++) begin
      if (n_failed != f0) break;
      @(negedge comm_clk);
    end
    cycles(300);
    chk("retry_total_bytes", 64'(txq.size()), 64'(60 * (T_RETRY + 1)));
    chk("retry_failed_count", 64'(n_failed - f0), 64'd1);
    chk("retry_no_ack", 64'(n_acked - a0), 64'd0);
    chk("retry_idle", 64'(busy), 64'd0);

    // ---------------- INVALID then ACK
    job[31:0] = $urandom;
    model_push(job);
    txq.delete();
    a0 = n_acked; f0 = n_failed;
    start_job(job);
    wait_tx("inv_tx1", 60, 2000);
    send_pkt(INVALID_PKT, 8);
    wait_tx("inv_tx2", 120, 2000);
    chk_pkt("inv_resend_pkt", 60);
    send_pkt(ACK_PKT, 8);
    chk("inv_ack_pulse", 64'(job_acked), 64'd1);
    cycles(200);
    chk("inv_ack_count", 64'(n_acked - a0), 64'd1);
    chk("inv_no_fail", 64'(n_failed - f0), 64'd0);
    chk("inv_no_extra_tx", 64'(txq.size()), 64'd120);

    // ---------------- NONCE during SEND
    txq.delete();
    a0 = n_acked;
    start_job(job);
    wait_tx("nonce_mid_tx", 20, 1000);
    send_pkt(128'h0C000003_00000000_DEADBEEF_00000000, 12);
    chk("nonce_mid_pulse", 64'(nonce_valid), 64'd1);
    chk("nonce_mid_value", 64'(nonce), 64'hDEADBEEF);
    chk("nonce_mid_busy", 64'(busy), 64'd1);
    wait_tx("nonce_job_tx", 60, 2000);
    send_pkt(ACK_PKT, 8);
    chk("nonce_job_ack", 64'(job_acked), 64'd1);
    cycles(3);
    chk("nonce_job_ack_count", 64'(n_acked - a0), 64'd1);

    // ---------------- INFO exchanges (fixed payload, then random)
    for (int k = 0; k < 4; k++) begin
      pk = {32'h10000000, 32'h00000000, (k == 0) ? 64'hDEADBEEF_13370D13 : {$urandom, $urandom}};
      txq.delete();
      i0 = n_info; p0 = n_perr;
      @(negedge comm_clk);
      info_req = 1'b1;
      @(negedge comm_clk);
      info_req = 1'b0;
      wait_tx("info_tx_count", 8, 500);
      acc = '0;
      for (int i = 0; i < 8 && i < txq.size(); i++) acc = {acc[55:0], txq[i]};
      chk("info_req_pkt", acc, 64'h08000000_00000000);
      send_pkt(pk, 16);
      chk("info_pulse", 64'(info_valid), 64'd1);
      chk("info_data", info_data, pk[63:0]);
      cycles(3);
      chk("info_count", 64'(n_info - i0), 64'd1);
      chk("info_no_err", 64'(n_perr - p0), 64'd0);
    end

    // ---------------- table of received packets while idle
    vecs[0] = '{"len5",        1,  128'h05000000_00000000_00000000_00000000, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{"len2",        1,  128'h02000000_00000000_00000000_00000000, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{"len7",        1,  128'h07000000_00000000_00000000_00000000, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{"pong",        1,  128'h01000000_00000000_00000000_00000000, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{"nonce",       12, 128'h0C000003_00000000_CAFEF00D_00000000, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[5] = '{"ack_unsolic", 8,  128'h08000004_00000000_00000000_00000000, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{"bad_type",    8,  128'h08000009_00000000_00000000_00000000, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{"nonce_len8",  8,  128'h08000003_00000000_00000000_00000000, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{"info_unsol",  16, 128'h10000000_00000000_11223344_55667788, 1'b1, 1'b0, 32'h0};
    vecs[9] = '{"ack_len12",   12, 128'h0C000004_00000000_12345678_00000000, 1'b1, 1'b0, 32'h0};
    foreach (vecs[v]) begin
      send_pkt(vecs[v].bytes, vecs[v].n);
      chk({vecs[v].name, "_err"}, 64'(proto_error), 64'(vecs[v].exp_err));
      chk({vecs[v].name, "_nv"}, 64'(nonce_valid), 64'(vecs[v].exp_nonce));
      if (vecs[v].exp_nonce) chk({vecs[v].name, "_val"}, 64'(nonce), 64'(vecs[v].exp_val));
      cycles(2);
    end

    // ---------------- randomized received packets vs reference model
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       begin rl = 8'd12; rt = 8'd3; end
        1:       begin rl = 8'($urandom_range(1, 7)); rt = 8'($urandom_range(0, 7)); end
        default: begin rl = 8'(8 + 4 * $urandom_range(0, 2)); rt = 8'($urandom_range(0, 7)); end
      endcase
      pk = '0;
      pk[127:120] = rl;
      pk[103:96]  = rt;
      pk[63:0]    = {$urandom, $urandom};
      exp_rx = model_rx(rl, rt);
      send_pkt(pk, (rl < 8'd8) ? 1 : int'(rl));
      chk("rand_err", 64'(proto_error), 64'(exp_rx[1]));
      chk("rand_nv", 64'(nonce_valid), 64'(exp_rx[0]));
      if (exp_rx[0]) chk("rand_nonce", 64'(nonce), 64'(pk[63:32]));
      chk("rand_no_ack_info", 64'({job_acked, info_valid}), 64'd0);
      cycles(2);
    end

    // ---------------- inter-byte gap timeout, then recovery
    p0 = n_perr;
    send_pkt(128'h0C000003_00000000_00000000_00000000, 5);
    cycles(T_GAP + 10);
    chk("gap_err_count", 64'(n_perr - p0), 64'd1);
    pk = {32'h0C000003, 32'h0, $urandom, 32'h0};
    send_pkt(pk, 12);
    chk("gap_recover_nv", 64'(nonce_valid), 64'd1);
    chk("gap_recover_val", 64'(nonce), 64'(pk[63:32]));

    // ---------------- reset mid-SEND
    start_job(job);
    wait_tx("rst_mid_tx", txq.size() + 10, 500);
    s0 = txq.size();
    a0 = n_acked; f0 = n_failed; p0 = n_perr; i0 = n_info; nn0 = n_nonce;
    @(negedge comm_clk);
    reset = 1'b1;
    @(negedge comm_clk);
    chk("rst_mid_transmit", 64'(transmit), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge comm_clk);
    chk("rst_mid_ready", 64'(job_ready), 64'd1);
    cycles(200);
    chk("rst_mid_silent", 64'(txq.size()), 64'(s0));

    // ---------------- reset mid-RX: partial packet is abandoned
    send_pkt(128'h0C000003_00000000_00000000_00000000, 6);
    @(negedge comm_clk);
    reset = 1'b1;
    @(negedge comm_clk);
    reset = 1'b0;
    pk = {32'h0C000003, 32'h0, $urandom, 32'h0};
    send_pkt(pk, 12);
    chk("rst_rx_nv", 64'(nonce_valid), 64'd1);
    chk("rst_rx_val", 64'(nonce), 64'(pk[63:32]));
    cycles(3);
    chk("rst_no_pulses", 64'((n_acked - a0) + (n_failed - f0) + (n_perr - p0) + (n_info - i0)), 64'd0);
    chk("rst_nonce_count", 64'(n_nonce - nn0), 64'd1);

    // ---------------- UART pacing over the whole run
    chk("tx_guard_violations", 64'(guard_viol), 64'd0);
    chk("tx_during_reset", 64'(reset_tx), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
